// File: rtl/bfp_comp_pkg.sv
// Shared types and constants for the bfp_comp front-end scheduler.
package bfp_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DROP = 2'd3
  } sched_state_e;

  localparam logic [3:0] COMP_METH_NONE = 4'd0;
  localparam logic [3:0] COMP_METH_BFP  = 4'd1;
  localparam int         WORDS_PER_PRB  = 6;

  // Values bfp_comp sees out of reset: BFP with 9-bit mantissas.
  localparam logic [3:0] CTRL_METH_RST     = 4'd1;
  localparam logic [3:0] CTRL_IQ_WIDTH_RST = 4'd9;

  function automatic logic meth_supported(input logic [3:0] meth);
    return (meth == COMP_METH_NONE) || (meth == COMP_METH_BFP);
  endfunction

endpackage

// File: rtl/bfp_rr_arb.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... modulo N_PORTS.
module bfp_rr_arb #(
  parameter int N_PORTS = 4,
  localparam int IDX_W  = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_PORTS);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_onehot
    assign grant[gi] = grant_vld && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/bfp_comp_sched.sv
// Packet-level round-robin scheduler sharing one bfp_comp between N_PORTS streams.
// Holds ctrl_ud_* stable per packet and delays config changes until bfp_comp drains.
// Optional statistics outputs are enabled with `define BFP_COMP_SCHED_STATS_EN.
module bfp_comp_sched #(
  parameter int N_PORTS         = 4,
  parameter int DATA_W          = 64,
  parameter int USER_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WORDS_PER_PRB   = bfp_comp_pkg::WORDS_PER_PRB
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS*DATA_W-1:0]  s_axis_tdata,
  input  logic [N_PORTS*DATA_W/8-1:0] s_axis_tkeep,
  input  logic [N_PORTS-1:0]         s_axis_tvalid,
  output logic [N_PORTS-1:0]         s_axis_tready,
  input  logic [N_PORTS-1:0]         s_axis_tlast,
  input  logic [N_PORTS*USER_W-1:0]  s_axis_tuser,
  input  logic [N_PORTS*4-1:0]       cfg_comp_meth,
  input  logic [N_PORTS*4-1:0]       cfg_iq_width,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [DATA_W/8-1:0]        m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic [USER_W-1:0]          m_axis_tuser,
  output logic [3:0]                 ctrl_ud_comp_meth,
  output logic [3:0]                 ctrl_ud_iq_width,
  input  logic                       comp_out_tvalid,
  input  logic                       comp_out_tlast,
  output logic                       busy,
  output logic                       err_len,
  output logic                       err_cfg
`ifdef BFP_COMP_SCHED_STATS_EN
  ,
  output logic [N_PORTS*16-1:0]      stat_pkt_cnt,
  output logic [31:0]                stat_wait_cyc
`endif
);

  import bfp_comp_pkg::*;

  localparam int IDX_W  = $clog2(N_PORTS);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WCNT_W = $clog2(WORDS_PER_PRB + 1);
  localparam int KEEP_W = DATA_W / 8;

  sched_state_e       state_reg, state_next;
  logic [IDX_W-1:0]   gnt_reg, rr_ptr_reg;
  logic [3:0]         snap_meth_reg, snap_width_reg;
  logic [3:0]         ctrl_meth_reg, ctrl_width_reg;
  logic [OUT_W-1:0]   outst_reg;
  logic [WCNT_W-1:0]  wcnt_reg;
  logic [DATA_W-1:0]  m_tdata_reg;
  logic [KEEP_W-1:0]  m_tkeep_reg;
  logic [USER_W-1:0]  m_tuser_reg, m_tuser_next;
  logic               m_tvalid_reg, m_tlast_reg, err_len_reg, err_cfg_reg;

  logic [N_PORTS-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [3:0]         sel_meth, sel_width;
  logic               idle_block, wait_block;
  logic               in_pkt, acc, acc_last, fwd_last, cmp_done;

  bfp_rr_arb #(.N_PORTS(N_PORTS)) u_arb (
    .req       (s_axis_tvalid),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Config of the port the arbiter would grant this cycle (one-hot AND-OR mux).
  always_comb begin
    sel_meth  = '0;
    sel_width = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (arb_grant[p]) begin
        sel_meth  = sel_meth  | cfg_comp_meth[p*4 +: 4];
        sel_width = sel_width | cfg_iq_width[p*4 +: 4];
      end
    end
  end

  // A packet may not start if it changes ctrl while bfp_comp still holds packets, or if bfp_comp is full.
  assign idle_block = (((sel_meth != ctrl_meth_reg) || (sel_width != ctrl_width_reg)) && (outst_reg != '0))
                      || (outst_reg == OUT_W'(MAX_OUTSTANDING));
  assign wait_block = (((snap_meth_reg != ctrl_meth_reg) || (snap_width_reg != ctrl_width_reg)) && (outst_reg != '0))
                      || (outst_reg == OUT_W'(MAX_OUTSTANDING));

  assign in_pkt   = (state_reg == XFER) || (state_reg == DROP);
  assign acc      = in_pkt && s_axis_tvalid[gnt_reg];
  assign acc_last = acc && s_axis_tlast[gnt_reg];
  assign fwd_last = acc_last && (state_reg == XFER);
  assign cmp_done = comp_out_tvalid && comp_out_tlast && (outst_reg != '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (arb_vld) begin
        if (!meth_supported(sel_meth)) state_next = DROP;
        else if (idle_block)           state_next = WAIT;
        else                           state_next = XFER;
      end
      WAIT: if (!wait_block) state_next = XFER;
      XFER: if (acc_last)    state_next = IDLE;
      DROP: if (acc_last)    state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // FSM outputs: only the granted port is ready, and only while its packet moves.
  always_comb begin
    s_axis_tready = '0;
    if (in_pkt) s_axis_tready[gnt_reg] = 1'b1;
    busy = (state_reg != IDLE) || (outst_reg != '0);
  end

  // Grant/snapshot capture, ctrl load on XFER entry, and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_reg        <= '0;
      rr_ptr_reg     <= IDX_W'(N_PORTS - 1);
      snap_meth_reg  <= '0;
      snap_width_reg <= '0;
      ctrl_meth_reg  <= CTRL_METH_RST;
      ctrl_width_reg <= CTRL_IQ_WIDTH_RST;
    end else begin
      if (state_reg == IDLE && arb_vld) begin
        gnt_reg        <= arb_idx;
        snap_meth_reg  <= sel_meth;
        snap_width_reg <= sel_width;
      end
      if (state_next == XFER && state_reg != XFER) begin
        ctrl_meth_reg  <= (state_reg == IDLE) ? sel_meth  : snap_meth_reg;
        ctrl_width_reg <= (state_reg == IDLE) ? sel_width : snap_width_reg;
      end
      if (acc_last) rr_ptr_reg <= gnt_reg;
    end
  end

  // Selected port's tuser with the low nibble replaced by the source index.
  always_comb begin
    m_tuser_next      = s_axis_tuser[gnt_reg*USER_W +: USER_W];
    m_tuser_next[3:0] = 4'(gnt_reg);
  end

  // One-cycle output register towards bfp_comp; DROP consumes without forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
      m_tdata_reg  <= '0;
      m_tkeep_reg  <= '0;
      m_tuser_reg  <= '0;
    end else begin
      m_tvalid_reg <= acc && (state_reg == XFER);
      m_tlast_reg  <= fwd_last;
      if (acc && state_reg == XFER) begin
        m_tdata_reg <= s_axis_tdata[gnt_reg*DATA_W +: DATA_W];
        m_tkeep_reg <= s_axis_tkeep[gnt_reg*KEEP_W +: KEEP_W];
        m_tuser_reg <= m_tuser_next;
      end
    end
  end

  // Packets in flight inside bfp_comp; a simultaneous start and finish cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    outst_reg <= '0;
    else if (fwd_last && !cmp_done) outst_reg <= outst_reg + OUT_W'(1);
    else if (cmp_done && !fwd_last) outst_reg <= outst_reg - OUT_W'(1);
  end

  // PRB word counter and error pulses; a bad length is flagged but the packet is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_reg    <= '0;
      err_len_reg <= 1'b0;
      err_cfg_reg <= 1'b0;
    end else begin
      err_len_reg <= acc_last && (wcnt_reg != WCNT_W'(WORDS_PER_PRB - 1));
      err_cfg_reg <= acc_last && (state_reg == DROP);
      if (acc) begin
        if (acc_last || wcnt_reg == WCNT_W'(WORDS_PER_PRB - 1)) wcnt_reg <= '0;
        else                                                    wcnt_reg <= wcnt_reg + WCNT_W'(1);
      end
    end
  end

  assign m_axis_tdata      = m_tdata_reg;
  assign m_axis_tkeep      = m_tkeep_reg;
  assign m_axis_tvalid     = m_tvalid_reg;
  assign m_axis_tlast      = m_tlast_reg;
  assign m_axis_tuser      = m_tuser_reg;
  assign ctrl_ud_comp_meth = ctrl_meth_reg;
  assign ctrl_ud_iq_width  = ctrl_width_reg;
  assign err_len           = err_len_reg;
  assign err_cfg           = err_cfg_reg;

`ifdef BFP_COMP_SCHED_STATS_EN
  logic [31:0] wait_cyc_reg;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_stat
    logic [15:0] pkt_cnt_reg;
    // Forwarded-packet count for this port; dropped packets never reach XFER.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    pkt_cnt_reg <= '0;
      else if (fwd_last && gnt_reg == IDX_W'(gi))    pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
    assign stat_pkt_cnt[gi*16 +: 16] = pkt_cnt_reg;
  end

  // Cycles lost waiting for bfp_comp to drain or free a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cyc_reg <= '0;
    else if (state_reg == WAIT) wait_cyc_reg <= wait_cyc_reg + 32'd1;
  end
  assign stat_wait_cyc = wait_cyc_reg;
`endif

endmodule

// File: tb/tb_bfp_comp_sched.sv
// Directed bench for bfp_comp_sched (4 ports, MAX_OUTSTANDING = 2).
module tb_bfp_comp_sched;

  localparam int NP = 4;

  logic              clk, rst_n;
  logic [NP*64-1:0]  s_axis_tdata;
  logic [NP*8-1:0]   s_axis_tkeep;
  logic [NP-1:0]     s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [NP*32-1:0]  s_axis_tuser;
  logic [NP*4-1:0]   cfg_comp_meth, cfg_iq_width;
  logic [63:0]       m_axis_tdata;
  logic [7:0]        m_axis_tkeep;
  logic              m_axis_tvalid, m_axis_tlast;
  logic [31:0]       m_axis_tuser;
  logic [3:0]        ctrl_ud_comp_meth, ctrl_ud_iq_width;
  logic              comp_out_tvalid, comp_out_tlast;
  logic              busy, err_len, err_cfg;
`ifdef BFP_COMP_SCHED_STATS_EN
  logic [NP*16-1:0]  stat_pkt_cnt;
  logic [31:0]       stat_wait_cyc;
`endif

  bfp_comp_sched #(.N_PORTS(NP), .DATA_W(64), .USER_W(32), .MAX_OUTSTANDING(2), .WORDS_PER_PRB(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .cfg_comp_meth(cfg_comp_meth), .cfg_iq_width(cfg_iq_width),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .ctrl_ud_comp_meth(ctrl_ud_comp_meth), .ctrl_ud_iq_width(ctrl_ud_iq_width),
    .comp_out_tvalid(comp_out_tvalid), .comp_out_tlast(comp_out_tlast),
`ifdef BFP_COMP_SCHED_STATS_EN
    .stat_pkt_cnt(stat_pkt_cnt), .stat_wait_cyc(stat_wait_cyc),
`endif
    .busy(busy), .err_len(err_len), .err_cfg(err_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, done_cnt = 0, fwd_cnt = 0, err_len_cnt = 0, err_cfg_cnt = 0;
  bit auto_cmp = 0;
  int pkt_q [NP][$];
  int src_w [NP];
  int src_pkt [NP];
  logic [3:0] cfg_m [NP];
  logic [3:0] cfg_w [NP];
  int grant_log[$];
  int grant_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_data(input int p, input int k, input int w);
    return {8'(p), 8'(k), 16'(w), 32'hC0DE_0000};
  endfunction

  function automatic logic [31:0] word_user(input int p, input int k, input int w);
    return {8'hA5, 4'(p), 4'(k), 8'(w), 8'h0F};
  endfunction

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      cfg_comp_meth[p*4 +: 4] = cfg_m[p];
      cfg_iq_width[p*4 +: 4]  = cfg_w[p];
      if (pkt_q[p].size() > 0) begin
        s_axis_tvalid[p]        = 1'b1;
        s_axis_tlast[p]         = (src_w[p] == pkt_q[p][0] - 1);
        s_axis_tdata[p*64 +: 64] = word_data(p, src_pkt[p], src_w[p]);
        s_axis_tkeep[p*8 +: 8]  = s_axis_tlast[p] ? 8'h0F : 8'hFF;
        s_axis_tuser[p*32 +: 32] = word_user(p, src_pkt[p], src_w[p]);
      end else begin
        s_axis_tvalid[p] = 1'b0;
        s_axis_tlast[p]  = 1'b0;
      end
    end
  endtask

  // One clock: predict the forwarded word from the handshake about to happen, then check it.
  task automatic tick();
    logic [3:0]  acc;
    logic        exp_v, e_l;
    logic [63:0] e_d;
    logic [7:0]  e_k;
    logic [31:0] e_u;
    acc = s_axis_tvalid & s_axis_tready;
    exp_v = 1'b0; e_l = 1'b0; e_d = '0; e_k = '0; e_u = '0;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && cfg_m[p] <= 4'd1) begin
        exp_v = 1'b1;
        e_d   = s_axis_tdata[p*64 +: 64];
        e_k   = s_axis_tkeep[p*8 +: 8];
        e_l   = s_axis_tlast[p];
        e_u   = {s_axis_tuser[p*32+4 +: 28], 4'(p)};
      end
    end
    if (auto_cmp) begin
      comp_out_tvalid = m_axis_tvalid & m_axis_tlast;
      comp_out_tlast  = m_axis_tvalid & m_axis_tlast;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("rdy_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
    check("m_tvalid", 64'(m_axis_tvalid), 64'(exp_v));
    if (exp_v) begin
      fwd_cnt++;
      check("m_tdata", m_axis_tdata, e_d);
      check("m_tkeep", 64'(m_axis_tkeep), 64'(e_k));
      check("m_tlast", 64'(m_axis_tlast), 64'(e_l));
      check("m_tuser", 64'(m_axis_tuser), 64'(e_u));
    end
    err_len_cnt += int'(err_len);
    err_cfg_cnt += int'(err_cfg);
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        if (src_w[p] == 0) begin
          grant_log.push_back(p);
          grant_cyc.push_back(cyc);
        end
        if (src_w[p] == pkt_q[p][0] - 1) begin
          $display("pkt port %0d #%0d len %0d done at cycle %0d", p, src_pkt[p], pkt_q[p][0], cyc);
          void'(pkt_q[p].pop_front());
          src_w[p] = 0;
          src_pkt[p]++;
          done_cnt++;
        end else begin
          src_w[p]++;
        end
      end
    end
    drive_inputs();
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("pkt_done", 64'(done_cnt), 64'(target));
  endtask

  task automatic pulse_comp();
    comp_out_tvalid = 1'b1;
    comp_out_tlast  = 1'b1;
    tick();
    comp_out_tvalid = 1'b0;
    comp_out_tlast  = 1'b0;
  endtask

  task automatic check_grants(input string tag, input int n, input int e0, input int e1, input int e2, input int e3);
    int exp_g [4];
    exp_g = '{e0, e1, e2, e3};
    check({tag, "_cnt"}, 64'(grant_log.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check(tag, 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(exp_g[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_len0, e_cfg0, fwd0, rdy3, n;
    rst_n = 1'b0;
    comp_out_tvalid = 1'b0;
    comp_out_tlast  = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    for (int p = 0; p < NP; p++) begin
      cfg_m[p] = 4'd1; cfg_w[p] = 4'd9; src_w[p] = 0; src_pkt[p] = 0;
    end
    drive_inputs();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_ctrl_meth", 64'(ctrl_ud_comp_meth), 64'd1);
    check("rst_ctrl_width", 64'(ctrl_ud_iq_width), 64'd9);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_errs", 64'({err_len, err_cfg, m_axis_tlast}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single PRB on port 0
    pkt_q[0].push_back(6);
    drive_inputs();
    tick();
    check("t1_first_rdy", 64'(s_axis_tready), 64'b0001);
    run_until(1, 20);
    check("t1_busy_outst", 64'(busy), 64'd1);
    check("t1_idle_rdy", 64'(s_axis_tready), 64'd0);
    pulse_comp();
    check("t1_drained", 64'(busy), 64'd0);

    // Test 2: ports 0 and 2 streaming; rr_ptr = 0 after test 1 so port 2 goes first
    grant_log.delete(); grant_cyc.delete();
    auto_cmp = 1;
    pkt_q[0].push_back(6); pkt_q[0].push_back(6);
    pkt_q[2].push_back(6); pkt_q[2].push_back(6);
    drive_inputs();
    run_until(5, 60);
    tick();
    auto_cmp = 0;
    comp_out_tvalid = 1'b0; comp_out_tlast = 1'b0;
    check_grants("t2_grant", 4, 2, 0, 2, 0);
    for (int i = 1; i < 4; i++)
      check("t2_gap", 64'((i < grant_cyc.size()) ? grant_cyc[i] - grant_cyc[i-1] : 0), 64'd7);
    check("t2_busy", 64'(busy), 64'd0);

    // Test 3: width change waits for drain
    grant_log.delete();
    pkt_q[1].push_back(6);
    drive_inputs();
    run_until(6, 20);
    check("t3_ctrl_w9", 64'(ctrl_ud_iq_width), 64'd9);
    cfg_w[2] = 4'd12;
    pkt_q[2].push_back(6);
    drive_inputs();
    repeat (4) begin
      tick();
      check("t3_wait_rdy", 64'(s_axis_tready), 64'd0);
      check("t3_wait_ctrl", 64'(ctrl_ud_iq_width), 64'd9);
    end
    pulse_comp();
    check("t3_ctrl_hold", 64'(ctrl_ud_iq_width), 64'd9);
    tick();
    check("t3_ctrl_w12", 64'(ctrl_ud_iq_width), 64'd12);
    check("t3_rdy2", 64'(s_axis_tready), 64'b0100);
    tick();
    check("t3_first_v", 64'(m_axis_tvalid), 64'd1);
    check("t3_first_d", m_axis_tdata, word_data(2, 2, 0));
    run_until(7, 20);
    pulse_comp();
    check("t3_busy", 64'(busy), 64'd0);

    // Test 4: outstanding limit of 2 holds the third packet
    grant_log.delete();
    cfg_w[0] = 4'd12; cfg_w[1] = 4'd12; cfg_w[3] = 4'd12;
    pkt_q[0].push_back(6); pkt_q[1].push_back(6); pkt_q[3].push_back(6);
    drive_inputs();
    run_until(9, 40);
    repeat (4) begin
      tick();
      check("t4_full_rdy", 64'(s_axis_tready), 64'd0);
    end
    check("t4_held", 64'(done_cnt), 64'd9);
    check("t4_busy", 64'(busy), 64'd1);
    pulse_comp();
    run_until(10, 30);
    check_grants("t4_grant", 3, 3, 0, 1, 0);
    pulse_comp();
    pulse_comp();
    check("t4_busy_end", 64'(busy), 64'd0);

    // Test 5: unsupported method on port 3 is dropped
    e_len0 = err_len_cnt; e_cfg0 = err_cfg_cnt; fwd0 = fwd_cnt;
    cfg_m[3] = 4'd5;
    pkt_q[3].push_back(12);
    drive_inputs();
    rdy3 = 0; n = 0;
    while (done_cnt < 11 && n < 40) begin
      tick();
      if (s_axis_tready == 4'b1000) rdy3++;
      n++;
    end
    check("t5_done", 64'(done_cnt), 64'd11);
    check("t5_rdy_cycles", 64'(rdy3), 64'd12);
    check("t5_err_cfg", 64'(err_cfg_cnt - e_cfg0), 64'd1);
    check("t5_err_len", 64'(err_len_cnt - e_len0), 64'd0);
    check("t5_fwd", 64'(fwd_cnt - fwd0), 64'd0);
    check("t5_ctrl_meth", 64'(ctrl_ud_comp_meth), 64'd1);
    check("t5_ctrl_width", 64'(ctrl_ud_iq_width), 64'd12);
    check("t5_busy", 64'(busy), 64'd0);
    cfg_m[3] = 4'd1;
    drive_inputs();

    // Test 6: 7-word packet flags err_len but is forwarded whole
    e_len0 = err_len_cnt; e_cfg0 = err_cfg_cnt; fwd0 = fwd_cnt;
    pkt_q[0].push_back(7);
    drive_inputs();
    run_until(12, 20);
    check("t6_err_len", 64'(err_len_cnt - e_len0), 64'd1);
    check("t6_fwd", 64'(fwd_cnt - fwd0), 64'd7);
    check("t6_err_cfg", 64'(err_cfg_cnt - e_cfg0), 64'd0);
    pulse_comp();

    // Test 7: reset in the middle of a packet
    pkt_q[1].push_back(12);
    drive_inputs();
    n = 0;
    while (src_w[1] < 3 && n < 20) begin
      tick();
      n++;
    end
    check("t7_words", 64'(src_w[1]), 64'd3);
    check("t7_pre_v", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_v", 64'(m_axis_tvalid), 64'd0);
    check("t7_rst_rdy", 64'(s_axis_tready), 64'd0);
    check("t7_rst_meth", 64'(ctrl_ud_comp_meth), 64'd1);
    check("t7_rst_width", 64'(ctrl_ud_iq_width), 64'd9);
    check("t7_rst_busy", 64'(busy), 64'd0);
    pkt_q[1].delete();
    src_w[1] = 0;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t7_post_rdy", 64'(s_axis_tready), 64'd0);
    check("t7_post_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
